// File: rtl/adc_sequencer.sv
// adc_sequencer: round-robin scanner for a 12-bit serial ADC with a 16-bit frame.
// Each frame is SETUP (cs low, sclk high), 16 sclk periods of SHIFT, then a
// cs-high GAP, for 34*CLK_DIV clk cycles from frame start to frame start.
// Optional feature macro: ADC_SEQ_STALL_EN. When defined, an unaccepted sample
// parks the sequencer in HOLD instead of being overwritten.
module adc_sequencer #(
    parameter int CLK_DIV = 4,
    parameter int NUM_CH  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  ch_mask,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_din,
    input  logic        adc_dout,
    output logic [11:0] sample,
    output logic [2:0]  sample_ch,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        busy,
    output logic        overrun
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
`ifdef ADC_SEQ_STALL_EN
    localparam logic [2:0] S_HOLD  = 3'd4;
`endif

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
    localparam logic [7:0] CH_EN  = 8'((1 << NUM_CH) - 1);

    logic [2:0]  state;
    logic [7:0]  cnt;       // clk cycles within the current phase
    logic [3:0]  bitc;      // frame bit index 0..15
    logic [2:0]  ch_q;      // channel of the current / last frame
    logic [10:0] shreg;     // only the last 11 captured bits are ever needed
    logic [7:0]  mask_eff;
    logic        start_ok;
    logic        div_end;
    logic        cap;
    logic        load;

    assign mask_eff = ch_mask & CH_EN;
    assign start_ok = en && (mask_eff != 8'd0);
    assign div_end  = (cnt == DIV_M1);
    // first clk cycle with sclk high inside SHIFT is the capture cycle
    assign cap      = (state == S_SHIFT) && adc_sclk && (cnt == 8'd0);
    assign load     = cap && (bitc == 4'd15);
    assign busy     = (state == S_SETUP) || (state == S_SHIFT) || (state == S_GAP);

    // control word bit k: channel number on bits 2..4, MSB first, else zero
    function automatic logic frame_bit(input logic [2:0] ch, input logic [3:0] k);
        case (k)
            4'd2:    return ch[2];
            4'd3:    return ch[1];
            4'd4:    return ch[0];
            default: return 1'b0;
        endcase
    endfunction

    // next enabled channel strictly after 'last', wrapping at NUM_CH
    function automatic logic [2:0] next_ch(input logic [2:0] last, input logic [7:0] m);
        logic [2:0] r;
        int         c;
        r = last;
        for (int i = NUM_CH; i >= 1; i--) begin
            c = (int'(last) + i) % NUM_CH;
            if (m[c[2:0]]) r = c[2:0];
        end
        return r;
    endfunction

    // frame sequencing FSM and the serial pins
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 8'd0;
            bitc     <= 4'd0;
            ch_q     <= 3'(NUM_CH - 1);
            adc_cs_n <= 1'b1;
            adc_sclk <= 1'b1;
            adc_din  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state    <= S_SETUP;
                        cnt      <= 8'd0;
                        adc_cs_n <= 1'b0;
                        ch_q     <= next_ch(ch_q, mask_eff);
                    end
                end
                S_SETUP: begin
                    if (div_end) begin
                        state    <= S_SHIFT;
                        cnt      <= 8'd0;
                        bitc     <= 4'd0;
                        adc_sclk <= 1'b0;
                        adc_din  <= frame_bit(ch_q, 4'd0);
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_SHIFT: begin
                    if (div_end) begin
                        cnt <= 8'd0;
                        if (!adc_sclk) begin
                            adc_sclk <= 1'b1;
                        end else if (bitc == 4'd15) begin
                            state    <= S_GAP;
                            adc_cs_n <= 1'b1;
                        end else begin
                            adc_sclk <= 1'b0;
                            bitc     <= bitc + 4'd1;
                            adc_din  <= frame_bit(ch_q, bitc + 4'd1);
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    if (div_end) begin
                        cnt <= 8'd0;
`ifdef ADC_SEQ_STALL_EN
                        if (sample_valid && !sample_ready) begin
                            state <= S_HOLD;
                        end else
`endif
                        if (start_ok) begin
                            state    <= S_SETUP;
                            adc_cs_n <= 1'b0;
                            ch_q     <= next_ch(ch_q, mask_eff);
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
`ifdef ADC_SEQ_STALL_EN
                S_HOLD: begin
                    if (!sample_valid || sample_ready) begin
                        cnt <= 8'd0;
                        if (start_ok) begin
                            state    <= S_SETUP;
                            adc_cs_n <= 1'b0;
                            ch_q     <= next_ch(ch_q, mask_eff);
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    // receive shift register, sample hand-off and overrun flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg        <= 11'd0;
            sample       <= 12'd0;
            sample_ch    <= 3'd0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (cap) shreg <= {shreg[9:0], adc_dout};
            if (load) begin
                sample       <= {shreg, adc_dout};
                sample_ch    <= ch_q;
                sample_valid <= 1'b1;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
`ifndef ADC_SEQ_STALL_EN
            if (load && sample_valid && !sample_ready) overrun <= 1'b1;
`endif
        end
    end

endmodule

// File: doc/adc_sequencer.md
ADC_SEQUENCER -- requirements
Module: adc_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 4: clk cycles per adc_sclk half-period; legal range 1..255.
REQ-002 Parameter NUM_CH, default 8: channels 0..NUM_CH-1 eligible for scanning; legal range 1..8.
REQ-003 clk  in  1  single system clock; all logic on posedge clk.
REQ-004 rst_n  in  1  synchronous, active-low reset.
REQ-005 en  in  1  scan enable, level-sensitive.
REQ-006 ch_mask  in  8  channel enable mask; bit i enables channel i; bits >= NUM_CH ignored.
REQ-007 adc_cs_n  out  1  ADC chip select, active low.
REQ-008 adc_sclk  out  1  ADC serial clock, idle high.
REQ-009 adc_din  out  1  control word to ADC, MSB first.
REQ-010 adc_dout  in  1  serial data from ADC, MSB first.
REQ-011 sample  out  12  last converted value.
REQ-012 sample_ch  out  3  channel of sample.
REQ-013 sample_valid  out  1  sample/sample_ch valid.
REQ-014 sample_ready  in  1  consumer accepts when high with sample_valid.
REQ-015 busy  out  1  high whenever adc_cs_n is low or the cs-high gap is in progress.
REQ-016 overrun  out  1  sticky: an unaccepted sample was overwritten.

Function
REQ-017 States: IDLE, SETUP, SHIFT, GAP, plus HOLD when stall is compiled in (REQ-032); encoding is implementation choice.
REQ-018 IDLE: adc_cs_n=1, adc_sclk=1; go to SETUP when en=1 and (ch_mask masked to NUM_CH) is nonzero.
REQ-019 On IDLE->SETUP, pick the next enabled channel, round-robin, strictly after the last converted channel (first frame after reset starts search at channel 0); ch_mask is sampled only at this point.
REQ-020 SETUP: adc_cs_n=0, adc_sclk=1 for CLK_DIV cycles, then SHIFT.
REQ-021 SHIFT: 16 sclk periods; each period is CLK_DIV cycles low then CLK_DIV cycles high.
REQ-022 adc_din changes only on sclk falling edges; frame bit k (k=0..15, MSB first) = channel[2-(k-2)] for k=2..4, else 0.
REQ-023 adc_dout is captured on the clk cycle where adc_sclk rises; bits k=4..15 form sample[11:0], MSB first; bits 0..3 discarded.
REQ-024 After the 16th rising edge: adc_cs_n=1 and enter GAP for CLK_DIV cycles with adc_sclk=1.
REQ-025 sample, sample_ch, sample_valid update on the cycle after the 16th rising edge; frame-start-to-frame-start period = 34*CLK_DIV cycles.
REQ-026 sample_valid clears on a cycle with sample_valid=1 and sample_ready=1, unless a new sample loads that same cycle (then it stays 1 with the new data).
REQ-027 GAP exit: if en=1 and mask nonzero, go to SETUP (new channel per REQ-019); else IDLE.
REQ-028 en deassert mid-frame: current frame completes and its sample is delivered; then IDLE.
REQ-029 Single enabled channel: converts that channel every frame.

Reset
REQ-030 While rst_n=0 at posedge clk: state=IDLE, adc_cs_n=1, adc_sclk=1, adc_din=0, sample=0, sample_ch=0, sample_valid=0, busy=0, overrun=0, last channel = NUM_CH-1.
REQ-031 Reset asserted mid-frame aborts the frame immediately; no partial sample is delivered.

Configuration
REQ-032 Macro ADC_SEQ_STALL_EN defined: if sample_valid=1 and not accepted at GAP exit, enter HOLD (cs_n=1, sclk=1) until accepted, then proceed per REQ-027; overrun is constant 0.
REQ-033 Macro ADC_SEQ_STALL_EN undefined: no HOLD; new sample overwrites an unaccepted one and sets overrun=1 until reset.

Verification
REQ-034 CLK_DIV=4, mask=8'h05, en=1, sample_ready=1, model returns 12'hA5C -> samples on ch 0,2,0,2, valid every 136 cycles, value 12'hA5C.
REQ-035 mask=8'h08 -> adc_din bits 2..4 = 0,1,1 every frame; sample_ch=3 every frame.
REQ-036 en dropped at frame SHIFT bit 7 -> that sample delivered, cs_n high, state IDLE, no further frames.
REQ-037 sample_ready=0 for 3 frames: STALL_EN defined -> cs_n stays high after first frame, overrun=0; undefined -> 3 frames run, sample = third value, overrun=1.
REQ-038 rst_n=0 at SHIFT bit 10 -> next cycle cs_n=1, sclk=1, sample_valid=0; next frame starts at channel 0.
REQ-039 mask=0 with en=1 -> remains IDLE, busy=0, cs_n=1.
